// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: fetch-stage state encoding and default constants.
package if_fetch_unit_pkg;
  typedef enum logic {S_FETCH = 1'b0, S_VALID = 1'b1} state_t;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;
endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// if_pc_reg: program counter with word-aligned redirect load, increment and hold.
module if_pc_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_redirect,
  input  logic        i_advance,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc
);
  logic [31:0] r_pc;
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else if (i_redirect) r_pc <= {i_target[31:2], 2'b00};
    else if (i_advance) r_pc <= r_pc + PC_INC;
  end
  assign o_pc = r_pc;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches over req/ready and feeds IF/ID with bubbles when idle.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] RD_IF,
  output logic [31:0] next_PC_IF,
  output logic        fetch_valid,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t        r_state, w_next;
  logic [31:0]   r_buf, r_count, w_pc;
  logic [WW-1:0] r_wait;
  logic          r_err, w_load, w_advance, w_wait_hit;

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .reset      (reset),
    .i_redirect (redirect_valid),
    .i_advance  (w_advance),
    .i_target   (redirect_pc),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else r_state <= w_next;
  end

  // Redirect wins over everything: it kills the request and any word on IF/ID this cycle.
  always_comb begin
    w_next      = r_state;
    imem_req    = 1'b0;
    RD_IF       = NOP_INSTR;
    fetch_valid = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    if (redirect_valid) begin
      w_next = S_FETCH;
    end else if (r_state == S_FETCH) begin
      imem_req = 1'b1;
      w_load   = imem_ready;
      w_next   = imem_ready ? S_VALID : S_FETCH;
    end else begin
      RD_IF       = r_buf;
      fetch_valid = 1'b1;
      w_advance   = !stall;
      w_next      = stall ? S_VALID : S_FETCH;
    end
  end

  assign w_wait_hit = imem_req && !imem_ready && (r_wait == WW'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf   <= NOP_INSTR;
      r_count <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) r_buf <= imem_rdata;
      if (w_advance) r_count <= r_count + 32'd1;
      if (redirect_valid || w_load) r_wait <= '0;
      else if (imem_req && r_wait != WW'(MAX_WAIT)) r_wait <= r_wait + WW'(1);
      if ((redirect_valid && redirect_pc[1:0] != 2'b00) || w_wait_hit) r_err <= 1'b1;
    end
  end

  assign imem_addr   = w_pc;
  assign next_PC_IF  = w_pc + PC_INC;
  assign fetch_error = r_err;
  assign fetch_count = r_count;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a scoreboard of expected IF/ID handoffs.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, fetch_valid, fetch_error;
  logic [31:0] imem_addr, imem_rdata, RD_IF, next_PC_IF, fetch_count;

  typedef struct packed {logic [31:0] rd; logic [31:0] npc;} exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .RD_IF          (RD_IF),
    .next_PC_IF     (next_PC_IF),
    .fetch_valid    (fetch_valid),
    .fetch_error    (fetch_error),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr == 32'hC) ? 32'h2010_0005 : {16'hC0DE, imem_addr[15:0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] rd, input logic [31:0] npc);
    exp_t e;
    e.rd  = rd;
    e.npc = npc;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (fetch_valid && !stall) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL handoff: unexpected word %h with no expected entry at %0t", RD_IF, $time);
        end else begin
          e = sb.pop_front();
          chk("handoff_rd", RD_IF, e.rd);
          chk("handoff_npc", next_PC_IF, e.npc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_rd", RD_IF, 32'h0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_err", fetch_error, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_npc", next_PC_IF, 32'h4);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_bubble", fetch_valid, 0);
      push({16'hC0DE, 16'(4 * i)}, 32'(4 * i + 4));
      @(negedge clk);
      #1;
      chk("t1_valid", fetch_valid, 1);
      @(negedge clk);
      #1;
    end
    chk("t1_cnt", fetch_count, 3);
    chk("t1_addr_next", imem_addr, 32'hC);
    push(32'h2010_0005, 32'h10);
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_rd_hold", RD_IF, 32'h2010_0005);
      chk("t2_npc_hold", next_PC_IF, 32'h10);
      chk("t2_req", imem_req, 0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("t2_cnt_held", fetch_count, 3);
    @(negedge clk);
    #1;
    chk("t2_addr_adv", imem_addr, 32'h10);
    chk("t2_cnt", fetch_count, 4);
    @(negedge clk);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("t3_rd_nop", RD_IF, 32'h0);
    chk("t3_valid", fetch_valid, 0);
    chk("t3_req", imem_req, 0);
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    #1;
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_cnt", fetch_count, 4);
    for (int k = 0; k < 3; k++) begin
      chk("t4_req", imem_req, 1);
      chk("t4_addr", imem_addr, 32'h40);
      chk("t4_valid", fetch_valid, 0);
      @(negedge clk);
      #1;
    end
    imem_ready = 1'b1;
    push(32'hC0DE_0040, 32'h44);
    chk("t4_err", fetch_error, 0);
    @(negedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk("t4_cnt", fetch_count, 5);
    chk("t4_err_after", fetch_error, 0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      #1;
      chk("t5_err_timeout", fetch_error, (i >= 15) ? 32'd1 : 32'd0);
    end
    imem_ready = 1'b1;
    push(32'hC0DE_0044, 32'h48);
    @(negedge clk);
    #1;
    chk("t5_err_sticky", fetch_error, 1);
    @(negedge clk);
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h43;
    #1;
    chk("t5_req_redirect", imem_req, 0);
    chk("t5_cnt", fetch_count, 6);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t5_addr", imem_addr, 32'h40);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req", imem_req, 1);
    chk("t6_rd", RD_IF, 32'h0);
    chk("t6_valid", fetch_valid, 0);
    chk("t6_err", fetch_error, 0);
    chk("t6_cnt", fetch_count, 0);
    chk("t6_npc", next_PC_IF, 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("t6_err_misalign", fetch_error, 1);
    chk("t6_addr_align", imem_addr, 32'h40);
    @(negedge clk);
    redirect_valid = 1'b0; imem_ready = 1'b1;
    #1;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t6_npc_wrap", next_PC_IF, 32'h0);
    push(32'hC0DE_FFFC, 32'h0);
    @(negedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk("t6_addr_wrap", imem_addr, 32'h0);
    chk("t6_cnt_after", fetch_count, 1);
    @(negedge clk);
    #3;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
